// File: rtl/multicycle_fetch_sequencer.sv
// Multicycle instruction sequencer: FETCH/ISSUE/WAIT state machine with handshaked
// instruction memory and execute, relative/absolute branches, halt, fault and perf counters.
module multicycle_fetch_sequencer #(
  parameter int unsigned         PC_W        = 10,
  parameter int unsigned         INSTR_W     = 9,
  parameter int unsigned         OFF_W       = 8,
  parameter logic [INSTR_W-1:0]  HALT_INSTR  = 9'b101100100,
  parameter logic [PC_W-1:0]     START_PC    = '0,
  parameter bit                  BRANCH_MODE = 1'b0,
  parameter bit                  WRAP_FAULT  = 1'b1,
  parameter int unsigned         TIMEOUT     = 15,
  parameter int unsigned         CNT_W       = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic [PC_W-1:0]    instr_addr,
  output logic               instr_req,
  input  logic [INSTR_W-1:0] instr_data,
  input  logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_issue,
  input  logic               exec_done,
  input  logic               branch,
  input  logic [OFF_W-1:0]   branch_operand,
  output logic               done,
  output logic               fault,
  output logic [CNT_W-1:0]   cycle_count,
  output logic [CNT_W-1:0]   retired_count
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_ISSUE, S_WAIT, S_DONE, S_FAULT
  } state_t;

  state_t             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [CNT_W-1:0]   cyc_q, cyc_d;
  logic [CNT_W-1:0]   ret_q, ret_d;

  logic               count_cyc;
  logic [PC_W:0]      off_ext;
  logic [PC_W:0]      pc_sum;

  // Next-PC at PC_W+1 bits: the top bit flags overflow past 2^PC_W-1 or underflow below 0.
  always_comb begin
    off_ext = {{(PC_W + 1 - OFF_W){branch_operand[OFF_W-1]}}, branch_operand};
    if (!branch) begin
      pc_sum = {1'b0, pc_q} + (PC_W+1)'(1);
    end else if (BRANCH_MODE) begin
      pc_sum = {1'b0, PC_W'(branch_operand)};
    end else begin
      pc_sum = {1'b0, pc_q} + off_ext;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    tmo_d     = tmo_q;
    cyc_d     = cyc_q;
    ret_d     = ret_q;
    count_cyc = 1'b0;

    case (state_q)
      S_FETCH: begin
        count_cyc = 1'b1;
        if (instr_valid) begin
          instr_d = instr_data;
          tmo_d   = '0;
          state_d = S_ISSUE;
        end else if (tmo_q == TMO_LAST) begin
          state_d = S_FAULT;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_ISSUE: begin
        // The halting decode cycle issues nothing and is not counted as active work.
        if (instr_q == HALT_INSTR) begin
          state_d = S_DONE;
        end else begin
          count_cyc = 1'b1;
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        count_cyc = 1'b1;
        if (exec_done) begin
          if (ret_q != '1) ret_d = ret_q + 1'b1;
          if (pc_sum[PC_W] && WRAP_FAULT) begin
            state_d = S_FAULT;
          end else begin
            pc_d    = pc_sum[PC_W-1:0];
            state_d = S_FETCH;
          end
        end
      end
      default: ;
    endcase

    if (count_cyc && (cyc_q != '1)) cyc_d = cyc_q + 1'b1;

    if (start) begin
      state_d = S_FETCH;
      pc_d    = START_PC;
      tmo_d   = '0;
      cyc_d   = '0;
      ret_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= START_PC;
      instr_q <= '0;
      tmo_q   <= '0;
      cyc_q   <= '0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      tmo_q   <= tmo_d;
      cyc_q   <= cyc_d;
      ret_q   <= ret_d;
    end
  end

  assign instr_addr    = (state_q == S_IDLE) ? '0 : pc_q;
  assign instr_req     = (state_q == S_FETCH);
  assign instr         = instr_q;
  assign instr_issue   = (state_q == S_ISSUE) && (instr_q != HALT_INSTR);
  assign done          = (state_q == S_DONE) || (state_q == S_FAULT);
  assign fault         = (state_q == S_FAULT);
  assign cycle_count   = cyc_q;
  assign retired_count = ret_q;

endmodule

// File: tb/tb_multicycle_fetch_sequencer.sv
// Directed bench: four sequencer configurations share stimulus; each reads its own
// address from a small behavioural instruction memory.
module tb_multicycle_fetch_sequencer;

  localparam logic [8:0] HALT = 9'b101100100;

  logic       clk;
  logic       reset;
  logic       start;
  logic       valid;
  logic       exec_done;
  logic       branch;
  logic [7:0] operand;
  logic [9:0] halt_addr;

  logic [9:0]  addr    [4];
  logic        req     [4];
  logic [8:0]  data    [4];
  logic [8:0]  ins     [4];
  logic        issue   [4];
  logic        done    [4];
  logic        fault   [4];
  logic [15:0] cyc     [4];
  logic [15:0] retired [4];

  int unsigned n_cmp;
  int unsigned n_err;

  function automatic logic [8:0] mem(input logic [9:0] a);
    if (a == halt_addr) return HALT;
    return {1'b0, ~a[7:0]};
  endfunction

  assign data[0] = mem(addr[0]);
  assign data[1] = mem(addr[1]);
  assign data[2] = mem(addr[2]);
  assign data[3] = mem(addr[3]);

  // 0: defaults, 1: absolute branches, 2: modulo wrap from 1020, 3: faulting from 1020
  multicycle_fetch_sequencer u_dut (
    .clk(clk), .reset(reset), .start(start), .instr_addr(addr[0]), .instr_req(req[0]),
    .instr_data(data[0]), .instr_valid(valid), .instr(ins[0]), .instr_issue(issue[0]),
    .exec_done(exec_done), .branch(branch), .branch_operand(operand), .done(done[0]),
    .fault(fault[0]), .cycle_count(cyc[0]), .retired_count(retired[0]));

  multicycle_fetch_sequencer #(.BRANCH_MODE(1'b1)) u_abs (
    .clk(clk), .reset(reset), .start(start), .instr_addr(addr[1]), .instr_req(req[1]),
    .instr_data(data[1]), .instr_valid(valid), .instr(ins[1]), .instr_issue(issue[1]),
    .exec_done(exec_done), .branch(branch), .branch_operand(operand), .done(done[1]),
    .fault(fault[1]), .cycle_count(cyc[1]), .retired_count(retired[1]));

  multicycle_fetch_sequencer #(.WRAP_FAULT(1'b0), .START_PC(10'd1020)) u_wrap (
    .clk(clk), .reset(reset), .start(start), .instr_addr(addr[2]), .instr_req(req[2]),
    .instr_data(data[2]), .instr_valid(valid), .instr(ins[2]), .instr_issue(issue[2]),
    .exec_done(exec_done), .branch(branch), .branch_operand(operand), .done(done[2]),
    .fault(fault[2]), .cycle_count(cyc[2]), .retired_count(retired[2]));

  multicycle_fetch_sequencer #(.START_PC(10'd1020)) u_hi (
    .clk(clk), .reset(reset), .start(start), .instr_addr(addr[3]), .instr_req(req[3]),
    .instr_data(data[3]), .instr_valid(valid), .instr(ins[3]), .instr_issue(issue[3]),
    .exec_done(exec_done), .branch(branch), .branch_operand(operand), .done(done[3]),
    .fault(fault[3]), .cycle_count(cyc[3]), .retired_count(retired[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic start_prog();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // One instruction with zero-wait memory and immediate exec_done: FETCH, ISSUE, WAIT.
  task automatic run_instr(input logic br, input logic [7:0] op);
    branch  = br;
    operand = op;
    repeat (3) @(negedge clk);
    branch  = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1; start = 1'b0; valid = 1'b0; exec_done = 1'b0;
    branch = 1'b0; operand = '0; halt_addr = 10'd3;
    repeat (2) @(negedge clk);

    check("rst_addr",    addr[0], 0);
    check("rst_req",     req[0], 0);
    check("rst_instr",   ins[0], 0);
    check("rst_issue",   issue[0], 0);
    check("rst_done",    done[0], 0);
    check("rst_fault",   fault[0], 0);
    check("rst_cycles",  cyc[0], 0);
    check("rst_retired", retired[0], 0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_req", req[0], 0);

    // Straight line: 3 instructions then HALT at pc=3
    valid = 1'b1; exec_done = 1'b1;
    start_prog();
    for (int k = 0; k < 12; k++) begin
      check("line_issue", issue[0], ((k % 3 == 1) && (k < 9)) ? 1 : 0);
      if ((k % 3 == 0) && (k < 12)) check("line_addr", addr[0], k / 3);
      if (k == 1) check("line_instr0", ins[0], 9'h0FF);
      @(negedge clk);
    end
    check("line_done",    done[0], 1);
    check("line_fault",   fault[0], 0);
    check("line_pc",      addr[0], 3);
    check("line_req",     req[0], 0);
    check("line_retired", retired[0], 3);
    check("line_cycles",  cyc[0], 10);
    repeat (3) @(negedge clk);
    check("done_hold_cycles", cyc[0], 10);

    // Relative branches
    halt_addr = 10'd999;
    start_prog();
    repeat (5) run_instr(1'b0, 8'h00);
    check("rel_pc5", addr[0], 5);
    run_instr(1'b1, 8'hFD);
    check("rel_back", addr[0], 2);
    run_instr(1'b1, 8'h04);
    check("rel_fwd", addr[0], 6);
    check("rel_retired", retired[0], 7);

    // Absolute target; the same operand underflows the relative configuration
    start_prog();
    repeat (3) run_instr(1'b0, 8'h00);
    check("abs_pc3", addr[1], 3);
    run_instr(1'b1, 8'hC8);
    check("abs_target", addr[1], 200);
    check("abs_fault",  fault[1], 0);
    check("under_fault", fault[0], 1);
    check("under_pc",    addr[0], 3);

    // Overflow past 1023
    start_prog();
    check("ovf_start", addr[3], 1020);
    run_instr(1'b1, 8'h0A);
    check("ovf_fault",   fault[3], 1);
    check("ovf_done",    done[3], 1);
    check("ovf_pc",      addr[3], 1020);
    check("ovf_retired", retired[3], 1);
    check("wrap_pc",     addr[2], 6);
    check("wrap_fault",  fault[2], 0);
    check("wrap_req",    req[2], 1);

    // Memory stall of 4 cycles
    valid = 1'b0;
    start_prog();
    for (int k = 0; k < 4; k++) begin
      check("stall_req",  req[0], 1);
      check("stall_addr", addr[0], 0);
      @(negedge clk);
    end
    valid = 1'b1;
    @(negedge clk);
    check("stall_issue",  issue[0], 1);
    check("stall_instr",  ins[0], 9'h0FF);
    check("stall_cycles", cyc[0], 5);

    // Timeout with no instr_valid
    valid = 1'b0;
    start_prog();
    repeat (14) @(negedge clk);
    check("tmo_not_yet", fault[0], 0);
    check("tmo_req",     req[0], 1);
    @(negedge clk);
    check("tmo_fault",  fault[0], 1);
    check("tmo_done",   done[0], 1);
    check("tmo_cycles", cyc[0], 15);

    // Restart during WAIT, exec_done high in the same cycle
    valid = 1'b1;
    start_prog();
    repeat (2) run_instr(1'b0, 8'h00);
    repeat (2) @(negedge clk);
    check("wait_retired", retired[0], 2);
    start_prog();
    check("rs_addr",    addr[0], 0);
    check("rs_req",     req[0], 1);
    check("rs_retired", retired[0], 0);
    check("rs_cycles",  cyc[0], 0);

    // Async reset mid-FETCH, observed before the next rising edge
    run_instr(1'b0, 8'h00);
    check("pre_rst_instr", ins[0], 9'h0FF);
    #2 reset = 1'b1;
    #1;
    check("arst_addr",    addr[0], 0);
    check("arst_req",     req[0], 0);
    check("arst_instr",   ins[0], 0);
    check("arst_done",    done[0], 0);
    check("arst_cycles",  cyc[0], 0);
    check("arst_retired", retired[0], 0);
    @(negedge clk);
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
